or_gate: RTL and testbench

Registered, width-parameterised bitwise OR stage with a ready/valid handshake on both sides. It computes y = a | b per bit and holds the result in a one-entry output register until the downstream consumer accepts it. It sits as a drop-in logic/pipeline element inside the full-adder datapath: the carry-out merge, (a·b) | (cin·(a^b)), at WIDTH=1, or a wider vector merge elsewhere.

---
 rtl/or_gate.sv | 77 +++++++
 tb/tb_or_gate.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/or_gate.sv
// or_gate: registered bitwise OR stage (y = a | b) with ready/valid handshake on both sides.
// Optional macro OR_GATE_COVER_EN adds cover_o, a sticky truth-table coverage register for bit 0.
`timescale 1ns/1ps
module or_gate #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             any_y,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OR_GATE_COVER_EN
  // "cover" is a reserved word, hence the suffix
  , output logic [3:0]     cover_o
`endif
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             any_q, any_d;
  logic             valid_q, valid_d;
  logic             accept, drain;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = valid_q && out_ready;

  always_comb begin
    y_d     = y_q;
    any_d   = any_q;
    valid_d = valid_q;
    if (accept) begin
      y_d     = a | b;
      any_d   = |(a | b);
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      any_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      any_q   <= any_d;
      valid_q <= valid_d;
    end
  end

  assign y         = y_q;
  assign any_y     = any_q;
  assign out_valid = valid_q;

`ifdef OR_GATE_COVER_EN
  logic [3:0] cover_q, cover_d;

  always_comb begin
    cover_d = cover_q;
    if (accept) cover_d[{a[0], b[0]}] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cover_q <= '0;
    else     cover_q <= cover_d;
  end

  assign cover_o = cover_q;
`endif

endmodule

// File: tb/tb_or_gate.sv
// Scoreboard bench for or_gate: a WIDTH=1 and a WIDTH=8 instance share handshake stimulus.
`timescale 1ns/1ps
module tb_or_gate;

  typedef struct packed {
    logic [7:0] y8;
    logic       any8;
    logic       y1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  exp_t       drv_exp = '0;

  logic       in_ready1, out_valid1, any1;
  logic [0:0] y1;
  logic       in_ready8, out_valid8, any8;
  logic [7:0] y8;
`ifdef OR_GATE_COVER_EN
  logic [3:0] cover1, cover8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  exp_t       q[$];
  exp_t       last_m = '0;
  logic       mvalid = 1'b0;
  logic [3:0] cov_m = '0;
  int         rst_cnt = 0;
  int         rst_ack = 0;

  or_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a8[0:0]), .b(b8[0:0]), .in_valid(in_valid),
    .in_ready(in_ready1), .y(y1), .any_y(any1), .out_valid(out_valid1),
    .out_ready(out_ready)
`ifdef OR_GATE_COVER_EN
    , .cover_o(cover1)
`endif
  );

  or_gate #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
    .in_ready(in_ready8), .y(y8), .any_y(any8), .out_valid(out_valid8),
    .out_ready(out_ready)
`ifdef OR_GATE_COVER_EN
    , .cover_o(cover8)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Handshake model: predicts accepts independently of the DUT and queues the hand-computed result.
  always @(posedge clk) begin
    if (rst) begin
      mvalid  <= 1'b0;
      last_m  <= '0;
      cov_m   <= '0;
      rst_cnt <= rst_cnt + 1;
    end else if (in_valid && (!mvalid || out_ready)) begin
      q.push_back(drv_exp);
      last_m <= drv_exp;
      mvalid <= 1'b1;
      cov_m[{a8[0], b8[0]}] <= 1'b1;
    end else if (mvalid && out_ready) begin
      mvalid <= 1'b0;
    end
  end

  // Monitor: samples on the falling edge, pops on each drain.
  always @(negedge clk) begin
    if (rst_cnt > 0) begin
      if (rst_ack != rst_cnt) begin
        q.delete();
        rst_ack = rst_cnt;
      end
      chk("out_valid1", out_valid1, mvalid);
      chk("out_valid8", out_valid8, mvalid);
      chk("in_ready1", in_ready1, !mvalid || out_ready);
      chk("in_ready8", in_ready8, !mvalid || out_ready);
`ifdef OR_GATE_COVER_EN
      chk("cover1", cover1, cov_m);
      chk("cover8", cover8, cov_m);
`endif
      if (mvalid) begin
        if (q.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          chk("y8", y8, q[0].y8);
          chk("any8", any8, q[0].any8);
          chk("y1", y1, q[0].y1);
          chk("any1", any1, q[0].y1);
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("hold_y8", y8, last_m.y8);
        chk("hold_any8", any8, last_m.any8);
        chk("hold_y1", y1, last_m.y1);
        chk("hold_any1", any1, last_m.y1);
      end
    end
  end

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v, input logic r,
                      input logic [7:0] ey8, input logic eany8, input logic ey1);
    a8 = a; b8 = b; in_valid = v; out_ready = r;
    drv_exp = '{y8: ey8, any8: eany8, y1: ey1};
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_y8", y8, 8'h00);
    chk("rst_out_valid1", out_valid1, 1'b0);
    chk("rst_in_ready1", in_ready1, 1'b1);

    // Truth table on bit 0, one pair per cycle
    step(8'h00, 8'h00, 1, 1, 8'h00, 0, 0);
    step(8'h00, 8'h01, 1, 1, 8'h01, 1, 1);
    step(8'h01, 8'h00, 1, 1, 8'h01, 1, 1);
    step(8'h01, 8'h01, 1, 1, 8'h01, 1, 1);
    chk("tt_y1_last", y1, 1'b1);
`ifdef OR_GATE_COVER_EN
    chk("tt_cover_full", cover1, 4'b1111);
`endif
    step(8'h00, 8'h00, 0, 1, 8'h00, 0, 0);

    // Wide vectors
    step(8'hA5, 8'h0F, 1, 1, 8'hAF, 1, 1);
    chk("w8_y", y8, 8'hAF);
    step(8'h00, 8'h00, 1, 1, 8'h00, 0, 0);
    chk("w8_zero_any", any8, 1'b0);
    step(8'h00, 8'h00, 0, 1, 8'h00, 0, 0);

    // Backpressure: result frozen while consumer stalls
    step(8'h01, 8'h00, 1, 0, 8'h01, 1, 1);
    repeat (3) step(8'h00, 8'h00, 1, 0, 8'h00, 0, 0);
    chk("bp_y1_frozen", y1, 1'b1);
    chk("bp_in_ready1", in_ready1, 1'b0);
    step(8'h00, 8'h00, 1, 1, 8'h00, 0, 0);
    chk("bp_y1_new", y1, 1'b0);
    step(8'h00, 8'h00, 0, 1, 8'h00, 0, 0);

    // Drain and accept every cycle
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(8'h00, 8'h00, 1, 1, 8'h00, 0, 0);
      else            step(8'hFF, 8'hFF, 1, 1, 8'hFF, 1, 1);
    end
    step(8'h00, 8'h00, 0, 1, 8'h00, 0, 0);

    // Reset with a pending result and a simultaneous accept
    step(8'h01, 8'h00, 1, 0, 8'h01, 1, 1);
    rst = 1'b1;
    step(8'h01, 8'h01, 1, 0, 8'h01, 1, 1);
    rst = 1'b0;
    chk("mid_rst_y1", y1, 1'b0);
    chk("mid_rst_y8", y8, 8'h00);
    chk("mid_rst_valid", out_valid1, 1'b0);
    chk("mid_rst_in_ready", in_ready1, 1'b1);
`ifdef OR_GATE_COVER_EN
    chk("mid_rst_cover", cover1, 4'b0000);
`endif
    step(8'h00, 8'h00, 0, 1, 8'h00, 0, 0);
    step(8'h00, 8'h00, 0, 1, 8'h00, 0, 0);
    chk("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
